regfile_mp: RTL and testbench

Parametrised multi-port register file with an integrated pending-write scoreboard, the next-generation general-purpose register file of the 5-stage pipeline. It provides NUM_RD combinational read ports and two write ports: writeback and a late load-return port. Per-register pending bits let the decode stage detect RAW hazards on in-flight results. Compile-time internal write-to-read bypass makes same-cycle writeback data visible to decode.

---
 rtl/regfile_mp.sv | 101 ++++++++++
 tb/tb_regfile_mp.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and clear busy) on matching read ports.
module regfile_mp #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_dst,
    output logic                     any_pending
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;

    function automatic logic is_r0(input logic [ADDR_W-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    logic wr0_ok, wr1_ok, iss_ok;
    assign wr0_ok = wr0_en && !is_r0(wr0_addr);
    assign wr1_ok = wr1_en && !is_r0(wr1_addr);
    assign iss_ok = iss_en && !is_r0(iss_dst);

    // wr1 is applied after wr0 so it wins a collision; issue is applied last so set beats clear.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (wr0_ok) begin
            mem_d[wr0_addr]  = wr0_data;
            pend_d[wr0_addr] = 1'b0;
        end
        if (wr1_ok) begin
            mem_d[wr1_addr]  = wr1_data;
            pend_d[wr1_addr] = 1'b0;
        end
        if (iss_ok) begin
            pend_d[iss_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    assign any_pending = |pend_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdat;
        logic              rbusy;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rdat  = mem_q[ra];
            rbusy = pend_q[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr1_ok && (wr1_addr == ra)) begin
                rdat  = wr1_data;
                rbusy = 1'b0;
            end else if (wr0_ok && (wr0_addr == ra)) begin
                rdat  = wr0_data;
                rbusy = 1'b0;
            end
`endif
            if (is_r0(ra)) begin
                rdat  = '0;
                rbusy = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = rdat;
        assign rd_busy[k]                  = rbusy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 4-read-port instance for the main table and
// a ZERO_R0=1 instance for the hard-wired zero register.
module tb_regfile_mp;

    logic        clk;
    logic        rst;

    logic [15:0] rd_addr;
    logic [63:0] rd_data;
    logic [3:0]  rd_busy;
    logic        wr0_en, wr1_en, iss_en;
    logic [3:0]  wr0_addr, wr1_addr, iss_dst;
    logic [15:0] wr0_data, wr1_data;
    logic        any_pending;

    logic [7:0]  z_rd_addr;
    logic [31:0] z_rd_data;
    logic [1:0]  z_rd_busy;
    logic        z_wr0_en, z_wr1_en, z_iss_en;
    logic [3:0]  z_wr0_addr, z_wr1_addr, z_iss_dst;
    logic [15:0] z_wr0_data, z_wr1_data;
    logic        z_any_pending;

    int n_chk;
    int n_fail;

    regfile_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4), .ZERO_R0(0)) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_dst(iss_dst), .any_pending(any_pending)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst),
        .rd_addr(z_rd_addr), .rd_data(z_rd_data), .rd_busy(z_rd_busy),
        .wr0_en(z_wr0_en), .wr0_addr(z_wr0_addr), .wr0_data(z_wr0_data),
        .wr1_en(z_wr1_en), .wr1_addr(z_wr1_addr), .wr1_data(z_wr1_data),
        .iss_en(z_iss_en), .iss_dst(z_iss_dst), .any_pending(z_any_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w0e;
        logic [3:0]  w0a;
        logic [15:0] w0d;
        logic        w1e;
        logic [3:0]  w1a;
        logic [15:0] w1d;
        logic        ie;
        logic [3:0]  id;
        logic [15:0] ra;   // port k address in nibble k
        logic [63:0] ed;   // port k expected data in [k*16 +: 16]
        logic [3:0]  eb;
        logic        ep;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mkv(input logic w0e, input logic [3:0] w0a, input logic [15:0] w0d,
                                 input logic w1e, input logic [3:0] w1a, input logic [15:0] w1d,
                                 input logic ie, input logic [3:0] id, input logic [15:0] ra,
                                 input logic [63:0] ed, input logic [3:0] eb, input logic ep);
        vec_t v;
        v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
        v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
        v.ie  = ie;  v.id  = id;  v.ra  = ra;
        v.ed  = ed;  v.eb  = eb;  v.ep  = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0;
        z_wr0_en = 1'b0; z_wr1_en = 1'b0; z_iss_en = 1'b0;
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        wr0_en = v.w0e; wr0_addr = v.w0a; wr0_data = v.w0d;
        wr1_en = v.w1e; wr1_addr = v.w1a; wr1_data = v.w1d;
        iss_en = v.ie;  iss_dst  = v.id;
        @(posedge clk);
        #1;
        clear_inputs();
        rd_addr = v.ra;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("vec%0d data p%0d", idx, k), {48'd0, rd_data[k*16 +: 16]}, {48'd0, v.ed[k*16 +: 16]});
            chk($sformatf("vec%0d busy p%0d", idx, k), {63'd0, rd_busy[k]}, {63'd0, v.eb[k]});
        end
        chk($sformatf("vec%0d any_pending", idx), {63'd0, any_pending}, {63'd0, v.ep});
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        clear_inputs();
        wr0_addr = '0; wr0_data = '0; wr1_addr = '0; wr1_data = '0; iss_dst = '0;
        z_wr0_addr = '0; z_wr0_data = '0; z_wr1_addr = '0; z_wr1_data = '0; z_iss_dst = '0;
        rd_addr = 16'h0005;
        z_rd_addr = 8'h00;

        vecs[0] = mkv(1, 4'h1, 16'h0001, 1, 4'h2, 16'h0002, 0, 4'h0, 16'h3021, 64'h0000_0000_0002_0001, 4'b0000, 0);
        vecs[1] = mkv(1, 4'h3, 16'h0003, 1, 4'h4, 16'h0004, 0, 4'h0, 16'h4321, 64'h0004_0003_0002_0001, 4'b0000, 0);
        vecs[2] = mkv(1, 4'h3, 16'hAAAA, 1, 4'h3, 16'h5555, 0, 4'h0, 16'h2143, 64'h0002_0001_0004_5555, 4'b0000, 0);
        vecs[3] = mkv(0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 1, 4'h7, 16'h0737, 64'h0000_0000_5555_0000, 4'b0101, 1);
        vecs[4] = mkv(1, 4'h7, 16'h00FF, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h7777, 64'h00FF_00FF_00FF_00FF, 4'b0000, 0);
        vecs[5] = mkv(1, 4'h7, 16'h1111, 0, 4'h0, 16'h0000, 1, 4'h7, 16'h2137, 64'h0002_0001_5555_1111, 4'b0001, 1);
        vecs[6] = mkv(0, 4'h0, 16'h0000, 1, 4'h7, 16'h2222, 1, 4'h9, 16'h4097, 64'h0004_0000_0000_2222, 4'b0010, 1);
        vecs[7] = mkv(1, 4'h9, 16'h0999, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h7979, 64'h2222_0999_2222_0999, 4'b0000, 0);
        vecs[8] = mkv(0, 4'h0, 16'h0000, 1, 4'h0, 16'h0F0F, 1, 4'h0, 16'h3210, 64'h5555_0002_0001_0F0F, 4'b0001, 1);
        vecs[9] = mkv(1, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h7F00, 64'h2222_0000_0000_0000, 4'b0000, 0);

        // Writes and issues presented while reset is held must be ignored.
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 4'h5; wr0_data = 16'h1234;
        iss_en = 1'b1; iss_dst = 4'h5;
        @(posedge clk);
        #1;
        chk("in-reset r5 data", {48'd0, rd_data[15:0]}, 64'h0);
        chk("in-reset r5 busy", {63'd0, rd_busy[0]}, 64'h0);
        chk("in-reset any_pending", {63'd0, any_pending}, 64'h0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        #1;
        chk("post-reset r5 data", {48'd0, rd_data[15:0]}, 64'h0);
        chk("post-reset any_pending", {63'd0, any_pending}, 64'h0);

        for (int i = 0; i < 10; i++) begin
            apply(i, vecs[i]);
        end

        // Bypass window: r2 pending and holding 0x0002, wr1 r2=0xBEEF read on port 1.
        @(negedge clk);
        iss_en = 1'b1; iss_dst = 4'h2;
        @(posedge clk);
        #1;
        clear_inputs();
        @(negedge clk);
        wr1_en = 1'b1; wr1_addr = 4'h2; wr1_data = 16'hBEEF;
        rd_addr = {4'h0, 4'h0, 4'h2, 4'h5};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass same-cycle data", {48'd0, rd_data[31:16]}, 64'hBEEF);
        chk("bypass same-cycle busy", {63'd0, rd_busy[1]}, 64'h0);
`else
        chk("no-bypass same-cycle data", {48'd0, rd_data[31:16]}, 64'h0002);
        chk("no-bypass same-cycle busy", {63'd0, rd_busy[1]}, 64'h1);
`endif
        chk("unmatched port data", {48'd0, rd_data[15:0]}, 64'h0);
        chk("same-cycle any_pending", {63'd0, any_pending}, 64'h1);
        @(posedge clk);
        #1;
        clear_inputs();
        #1;
        chk("after-write r2 data", {48'd0, rd_data[31:16]}, 64'hBEEF);
        chk("after-write r2 busy", {63'd0, rd_busy[1]}, 64'h0);
        chk("after-write any_pending", {63'd0, any_pending}, 64'h0);

        // Reset between edges clears array and scoreboard immediately.
        @(negedge clk);
        wr0_en = 1'b1; wr0_addr = 4'h5; wr0_data = 16'h1234;
        iss_en = 1'b1; iss_dst = 4'h6;
        @(posedge clk);
        #1;
        clear_inputs();
        rd_addr = {4'h0, 4'h6, 4'h2, 4'h5};
        #1;
        chk("pre-reset r5 data", {48'd0, rd_data[15:0]}, 64'h1234);
        chk("pre-reset r6 busy", {63'd0, rd_busy[2]}, 64'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("async reset r5 data", {48'd0, rd_data[15:0]}, 64'h0);
        chk("async reset r2 data", {48'd0, rd_data[31:16]}, 64'h0);
        chk("async reset r6 busy", {63'd0, rd_busy[2]}, 64'h0);
        chk("async reset any_pending", {63'd0, any_pending}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // ZERO_R0 instance: r0 ignores writes and issues, even within the write cycle.
        @(negedge clk);
        z_wr0_en = 1'b1; z_wr0_addr = 4'h0; z_wr0_data = 16'hFFFF;
        z_wr1_en = 1'b1; z_wr1_addr = 4'h1; z_wr1_data = 16'h0101;
        z_iss_en = 1'b1; z_iss_dst = 4'h0;
        z_rd_addr = {4'h1, 4'h0};
        #1;
        chk("r0 same-cycle data", {48'd0, z_rd_data[15:0]}, 64'h0);
        chk("r0 same-cycle busy", {63'd0, z_rd_busy[0]}, 64'h0);
        @(posedge clk);
        #1;
        clear_inputs();
        #1;
        chk("r0 data", {48'd0, z_rd_data[15:0]}, 64'h0);
        chk("r0 busy", {63'd0, z_rd_busy[0]}, 64'h0);
        chk("r0 any_pending", {63'd0, z_any_pending}, 64'h0);
        chk("zero-inst r1 data", {48'd0, z_rd_data[31:16]}, 64'h0101);
        @(negedge clk);
        z_iss_en = 1'b1; z_iss_dst = 4'h1;
        @(posedge clk);
        #1;
        clear_inputs();
        #1;
        chk("zero-inst r1 busy", {63'd0, z_rd_busy[1]}, 64'h1);
        chk("zero-inst any_pending", {63'd0, z_any_pending}, 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
